prio_onehot_encoder: RTL and testbench
======================================

// Module: prio_onehot_encoder
// PURPOSE
//  Registered priority encoder: the inverse of the sel->one-hot priority casez decoder.
//  It accepts an N-bit request vector on a valid/ready input and returns the index of the
//  highest-priority set bit on a valid/ready output. Priority is fixed: bit 0 is highest.
//  It also reports all-zero requests and counts beats that carry X/Z bits.
// PARAMETERS
//  N      4  request vector width, >=2; index width IW = $clog2(N)
//  CNT_W  8  width of the unknown-input event counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  req_valid  in   1      input beat valid
//  req_ready  out  1      block can accept a beat this cycle
//  req        in   N      request vector, may contain multiple set bits
//  out_valid  out  1      out_idx/out_none hold a result
//  out_ready  in   1      downstream accepts the result
//  out_idx    out  IW     index of the lowest-numbered set bit of the accepted req
//  out_none   out  1      accepted req was all-zero; out_idx = 0 in that case
//  clr_err    in   1      single-cycle pulse: clear err_x and x_count
//  err_x      out  1      sticky flag: an accepted beat contained X/Z
//  x_count    out  CNT_W  saturating count of dropped X/Z beats
// BEHAVIOUR
//  Reset (async, active-high): out_valid=0, out_idx=0, out_none=0, err_x=0, x_count=0.
//   state=EMPTY. Asserting rst mid-transfer discards the held result immediately.
//  FSM, 2 states:
//   EMPTY: out_valid=0. Moves to FULL on a clean accept.
//   FULL:  out_valid=1. Moves to EMPTY on out_ready with no clean accept.
//    Stays FULL on out_ready with a clean accept, loading the new result back-to-back.
//  req_ready = (state==EMPTY) | out_ready. It is combinational and carries no bubble.
//  Accept = req_valid & req_ready. The result is registered at the accept edge.
//  Latency: out_valid rises 1 cycle after accept. Throughput: 1 beat per cycle.
//  Encoding on a clean accept (req fully 0/1):
//   out_idx = min i such that req[i]=1; out_none=0.
//   If req==0: out_idx=0, out_none=1.
//   Examples for N=4: 0001->0, 0110->1, 1100->2, 1000->3.
//  Unknown input: an accept with $isunknown(req) is dropped.
//   No result is loaded and state does not change.
//   err_x<=1 and x_count<=x_count+1. x_count saturates at 2^CNT_W-1 and does not wrap.
//  Output stability: while out_valid & !out_ready, out_idx and out_none must not change.
//  clr_err: err_x<=0 and x_count<=0.
//   If clr_err coincides with a dropped X beat: err_x=1 and x_count=1, so the new event wins.
//  req_valid=0: no state change. req is ignored and may be X without any effect.
//  Encoding is a parameterised loop scanning from the MSB down to the LSB, so that the
//   LSB is written last and therefore wins priority. No casez on a fixed N.
// TESTING
//  1. Reset: hold rst with req_valid=1, req=4'b0001 ->
//     out_valid=0, err_x=0, x_count=0, req_ready=1.
//  2. Priority: send 0001, 0110, 1100, 1000 with out_ready=1 ->
//     out_idx 0, 1, 2, 3 on consecutive cycles, each 1 cycle after its accept.
//  3. Zero/backpressure: accept 0000, then out_ready=0 for 3 cycles ->
//     out_none=1, out_idx=0 held stable; req_ready=0; a second beat 0100 is not taken
//     until out_ready=1, then out_idx=2.
//  4. Unknown: accept 4'b0x10, then 4'b1z00 -> no out_valid; err_x=1; x_count=2.
//     A following clean 0010 -> out_idx=1.
//  5. Saturation/clear: CNT_W=2, send 5 X beats -> x_count=3.
//     clr_err together with an X beat -> x_count=1, err_x=1.
//     clr_err alone -> x_count=0, err_x=0.
//  6. Reset mid-op: rst pulsed while FULL with out_ready=0 ->
//     out_valid=0 asynchronously, with no cycle delay.

Source files
------------

// File: rtl/prio_onehot_encoder_if.sv
// Valid/ready bundle for the priority encoder.
// It carries the request channel and the result channel.
interface prio_onehot_encoder_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_none;

  modport slave (
    input  req_valid,
    input  req,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_idx,
    output out_none
  );

  modport master (
    output req_valid,
    output req,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_idx,
    input  out_none
  );
endinterface

// File: rtl/prio_onehot_encoder.sv
// Registered priority encoder (bit 0 wins), with a valid/ready in and out.
// Beats carrying X/Z are dropped and counted.
module prio_onehot_encoder #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  prio_onehot_encoder_if.slave     bus,
  input  logic                     clr_err,
  output logic                     err_x,
  output logic [CNT_W-1:0]         x_count
);
  localparam int IW = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              none_q, none_d;
  logic              err_x_q, err_x_d;
  logic [CNT_W-1:0]  x_count_q, x_count_d;

  logic              req_ready;
  logic              accept;
  logic              req_x;
  logic              clean_acc;
  logic              x_acc;
  logic [IW-1:0]     enc_idx;
  logic              enc_none;

  assign req_ready = (state_q == EMPTY) | bus.out_ready;
  assign accept    = bus.req_valid & req_ready;
  assign req_x     = $isunknown(bus.req);
  assign clean_acc = accept & ~req_x;
  assign x_acc     = accept & req_x;

  // MSB-to-LSB scan: the lowest set bit is written last and wins.
  always_comb begin
    enc_idx  = '0;
    enc_none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i] == 1'b1) begin
        enc_idx  = IW'(i);
        enc_none = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    none_d  = none_q;
    if (clean_acc) begin
      state_d = FULL;
      idx_d   = enc_idx;
      none_d  = enc_none;
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // A dropped beat in the same cycle as a clear counts as the first event.
  always_comb begin
    err_x_d   = err_x_q;
    x_count_d = x_count_q;
    if (clr_err) begin
      err_x_d   = 1'b0;
      x_count_d = '0;
    end
    if (x_acc) begin
      err_x_d = 1'b1;
      if (clr_err) begin
        x_count_d = CNT_W'(1);
      end else if (x_count_q != {CNT_W{1'b1}}) begin
        x_count_d = x_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      idx_q     <= '0;
      none_q    <= 1'b0;
      err_x_q   <= 1'b0;
      x_count_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      none_q    <= none_d;
      err_x_q   <= err_x_d;
      x_count_q <= x_count_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_idx   = idx_q;
  assign bus.out_none  = none_q;
  assign err_x         = err_x_q;
  assign x_count       = x_count_q;
endmodule

// File: tb/tb_prio_onehot_encoder.sv
// Directed bench for prio_onehot_encoder.
// Two instances: default widths, and CNT_W=2 for saturation.
module tb_prio_onehot_encoder;
  logic clk;
  logic rst;
  logic clr1, clr2;
  logic err1, err2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int tests;
  int fails;
  bit four_state;

  prio_onehot_encoder_if #(.N(4)) b1 ();
  prio_onehot_encoder_if #(.N(4)) b2 ();

  prio_onehot_encoder #(.N(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .clr_err(clr1), .err_x(err1), .x_count(cnt1)
  );

  prio_onehot_encoder #(.N(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .clr_err(clr2), .err_x(err2), .x_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    b1.req_valid = 1'b1;
    b1.req = 4'b0001;
    b1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", b1.out_valid);
    end
    tests++;
    if (err1 !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b want 0", err1);
    end
    tests++;
    if (cnt1 !== 8'd0) begin
      fails++; $display("FAIL reset_cnt got %0d want 0", cnt1);
    end
    tests++;
    if (b1.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", b1.req_ready);
    end
    tests++;
    if (b1.out_idx !== 2'd0 || b1.out_none !== 1'b0) begin
      fails++;
      $display("FAIL reset_out got idx=%0d none=%b want 0 0",
               b1.out_idx, b1.out_none);
    end
    b1.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle got %b want 0", b1.out_valid);
    end
  endtask

  task automatic test_priority();
    logic [3:0] vec [4];
    logic [1:0] exp [4];
    vec[0] = 4'b0001; exp[0] = 2'd0;
    vec[1] = 4'b0110; exp[1] = 2'd1;
    vec[2] = 4'b1100; exp[2] = 2'd2;
    vec[3] = 4'b1000; exp[3] = 2'd3;
    b1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1.req_valid = 1'b1;
      b1.req = vec[i];
      @(negedge clk);
      tests++;
      if (b1.out_valid !== 1'b1 || b1.out_idx !== exp[i] ||
          b1.out_none !== 1'b0) begin
        fails++;
        $display("FAIL prio_%0d got v=%b idx=%0d none=%b want 1 %0d 0",
                 i, b1.out_valid, b1.out_idx, b1.out_none, exp[i]);
      end
    end
    b1.req_valid = 1'b0;
    b1.req = 4'bxxxx;
    @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0) begin
      fails++; $display("FAIL prio_drain got %b want 0", b1.out_valid);
    end
  endtask

  task automatic test_backpressure();
    b1.req_valid = 1'b1;
    b1.req = 4'b0000;
    b1.out_ready = 1'b0;
    @(negedge clk);
    b1.req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (b1.out_valid !== 1'b1 || b1.out_none !== 1'b1 ||
          b1.out_idx !== 2'd0 || b1.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d got v=%b none=%b idx=%0d rdy=%b want 1 1 0 0",
                 c, b1.out_valid, b1.out_none, b1.out_idx, b1.req_ready);
      end
      if (c < 2) @(negedge clk);
    end
    b1.out_ready = 1'b1;
    #1;
    tests++;
    if (b1.req_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready got %b want 1", b1.req_ready);
    end
    @(negedge clk);
    b1.req_valid = 1'b0;
    tests++;
    if (b1.out_valid !== 1'b1 || b1.out_idx !== 2'd2 ||
        b1.out_none !== 1'b0) begin
      fails++;
      $display("FAIL bp_second got v=%b idx=%0d none=%b want 1 2 0",
               b1.out_valid, b1.out_idx, b1.out_none);
    end
    @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0 || err1 !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain got v=%b err=%b want 0 0", b1.out_valid, err1);
    end
  endtask

  task automatic test_unknown();
    b1.out_ready = 1'b1;
    b1.req_valid = 1'b1;
    b1.req = 4'b0x10;
    @(negedge clk);
    b1.req = 4'b1z00;
    @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0 || err1 !== 1'b1 || cnt1 !== 8'd2) begin
      fails++;
      $display("FAIL unk_drop got v=%b err=%b cnt=%0d want 0 1 2",
               b1.out_valid, err1, cnt1);
    end
    b1.req = 4'b0010;
    @(negedge clk);
    b1.req_valid = 1'b0;
    tests++;
    if (b1.out_valid !== 1'b1 || b1.out_idx !== 2'd1) begin
      fails++;
      $display("FAIL unk_clean got v=%b idx=%0d want 1 1",
               b1.out_valid, b1.out_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    b2.out_ready = 1'b1;
    b2.req_valid = 1'b1;
    b2.req = 4'bx000;
    repeat (5) @(negedge clk);
    tests++;
    if (cnt2 !== 2'd3 || err2 !== 1'b1) begin
      fails++;
      $display("FAIL sat got cnt=%0d err=%b want 3 1", cnt2, err2);
    end
    clr2 = 1'b1;
    @(negedge clk);
    tests++;
    if (cnt2 !== 2'd1 || err2 !== 1'b1) begin
      fails++;
      $display("FAIL clr_x got cnt=%0d err=%b want 1 1", cnt2, err2);
    end
    b2.req_valid = 1'b0;
    @(negedge clk);
    clr2 = 1'b0;
    tests++;
    if (cnt2 !== 2'd0 || err2 !== 1'b0 || b2.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clr got cnt=%0d err=%b v=%b want 0 0 0",
               cnt2, err2, b2.out_valid);
    end
  endtask

  task automatic test_reset_midop();
    b1.out_ready = 1'b0;
    b1.req_valid = 1'b1;
    b1.req = 4'b1000;
    @(negedge clk);
    b1.req_valid = 1'b0;
    tests++;
    if (b1.out_valid !== 1'b1 || b1.out_idx !== 2'd3) begin
      fails++;
      $display("FAIL mid_full got v=%b idx=%0d want 1 3",
               b1.out_valid, b1.out_idx);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (b1.out_valid !== 1'b0 || b1.out_idx !== 2'd0) begin
      fails++;
      $display("FAIL mid_async got v=%b idx=%0d want 0 0",
               b1.out_valid, b1.out_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (b1.out_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_after got v=%b rdy=%b want 0 1",
               b1.out_valid, b1.req_ready);
    end
  endtask

  initial begin
    logic [3:0] probe;
    tests = 0;
    fails = 0;
    clr1 = 1'b0;
    clr2 = 1'b0;
    b2.req_valid = 1'b0;
    b2.req = 4'b0000;
    b2.out_ready = 1'b1;
    // Two-state simulators cannot carry X/Z, so those scenarios need a 4-state run.
    probe = 4'bx0z0;
    four_state = $isunknown(probe);
    test_reset();
    test_priority();
    test_backpressure();
    if (four_state) begin
      test_unknown();
      test_saturation();
    end else begin
      $display("[TB] note: 2-state simulator, X/Z scenarios skipped");
    end
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
